// File: rtl/dma_read_unit.sv
// Streaming DMA read engine: issues NUM_WORDS sequential 64-bit reads to an arbiter
// and forwards the returned data in order through a credit-protected output FIFO.
module dma_read_unit #(
    parameter int NUM_WORDS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    output logic [63:0] out_data,
    input  logic        out_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | issuing read requests while FIFO credit allows
    // DRAIN | all requests accepted; waiting for returns and pops
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [16:0] TOTAL    = 17'(NUM_WORDS);
    localparam logic [CW:0] DEPTH    = (CW + 1)'(FIFO_DEPTH);

    state_t        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [15:0]   issue_cnt_q, issue_cnt_d;
    logic [16:0]   pop_cnt_q, pop_cnt_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [63:0]   fifo_q [FIFO_DEPTH];
    logic [63:0]   fifo_d [FIFO_DEPTH];
    logic          done_q, done_d;

    logic [CW:0]   inflight;
    logic          accept;
    logic          push;
    logic          pop;

    // Outstanding reads plus buffered words never exceed the FIFO depth, so a
    // granted read always has a slot waiting for its data.
    assign inflight  = {1'b0, outst_q} + {1'b0, count_q};
    assign mem_req   = (state_q == ISSUE) && (inflight < DEPTH);
    assign accept    = mem_req && mem_gnt;
    assign push      = mem_valid && (outst_q != '0);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
    assign mem_addr  = addr_q;
    assign out_data  = fifo_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        outst_d     = outst_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_d      = fifo_q;
        done_d      = 1'b0;

        if (accept && !push) begin
            outst_d = outst_q + CW'(1);
        end else if (!accept && push) begin
            outst_d = outst_q - CW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        if (push) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            pop_cnt_d = pop_cnt_q + 17'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    issue_cnt_d = '0;
                    pop_cnt_d   = '0;
                    outst_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d      = addr_q + 64'd8;
                    issue_cnt_d = issue_cnt_q + 16'd1;
                    if (issue_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((outst_q == '0) && (count_q == '0) && (pop_cnt_q == TOTAL)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            outst_q     <= outst_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
            fifo_q      <= fifo_d;
        end
    end

endmodule

// File: tb/tb_dma_read_unit.sv
// Scoreboard bench for dma_read_unit: a memory model answers requests, and
// monitors pop expected addresses/data queued when each transfer is started.
`timescale 1ns/1ps
module tb_dma_read_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] base_addr;
    logic        busy, done, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b1;
    logic        mem_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;

    dma_read_unit #(.NUM_WORDS(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    logic [63:0] ret_addr_q [$];
    int          ret_due_q [$];
    int          cyc = 0;
    int          lat = 2;
    int          stall_left = 0;
    logic [63:0] stall_addr = '0;
    int          grants = 0;
    int          done_cnt = 0;
    int          ignored_valids = 0;
    int          tb_outst = 0;
    int          tb_occ = 0;
    logic        req_hold = 1'b0;
    logic [63:0] req_addr = '0;
    logic        out_hold = 1'b0;
    logic [63:0] out_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model, request-side scoreboard and credit checks.
    always @(negedge clk) begin
        cyc++;
        if (ret_addr_q.size() > 0 && ret_due_q[0] <= cyc) begin
            mem_valid = 1'b1;
            mem_rdata = ret_addr_q.pop_front();
            void'(ret_due_q.pop_front());
        end else begin
            mem_valid = 1'b0;
            mem_rdata = '0;
        end
        mem_gnt = 1'b1;
        if (mem_req && stall_left > 0 && mem_addr == stall_addr) begin
            mem_gnt = 1'b0;
            stall_left--;
        end
        if (rst) begin
            tb_outst = 0;
            tb_occ   = 0;
            req_hold = 1'b0;
        end else begin
            if (req_hold) begin
                check("req_held", 64'(mem_req), 64'd1);
                check("addr_held", mem_addr, req_addr);
            end
            req_hold = mem_req && !mem_gnt;
            req_addr = mem_addr;
            if (tb_outst + tb_occ >= 4) check("req_no_credit", 64'(mem_req), 64'd0);
            if (mem_req) check("we_wdata_zero", {mem_wdata[62:0], mem_we}, 64'd0);
            if (mem_req && mem_gnt) begin
                grants++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected actual=%h required=none", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
                ret_addr_q.push_back(mem_addr);
                ret_due_q.push_back(cyc + lat);
            end
            if (mem_valid && tb_outst == 0) ignored_valids++;
            if (mem_req && mem_gnt) tb_outst++;
            if (mem_valid && tb_outst > 0) begin
                tb_outst--;
                tb_occ++;
            end
            if (out_valid && out_ready) tb_occ--;
        end
    end

    // Output-side scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            out_hold = 1'b0;
        end else begin
            if (out_hold) begin
                check("out_hold_valid", 64'(out_valid), 64'd1);
                check("out_hold_data", out_data, out_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%h required=none", out_data);
                end else begin
                    check("out_data", out_data, exp_data_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("done_busy_low", 64'(busy), 64'd0);
            end
            out_hold = out_valid && !out_ready;
            out_prev = out_data;
        end
    end

    task automatic launch(input logic [63:0] base);
        for (int i = 0; i < 16; i++) begin
            exp_addr_q.push_back(base + 64'(8 * i));
            exp_data_q.push_back(base + 64'(8 * i));
        end
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic finish_xfer(input string name, input bit toggle_ready);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            if (toggle_ready) out_ready = (n % 3 != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        repeat (5) tick();
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
        check({name, "_data_left"}, 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_mem_req"}, 64'(mem_req), 64'd0);
        check({name, "_mem_we"}, 64'(mem_we), 64'd0);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_mem_addr"}, mem_addr, 64'd0);
        check({name, "_mem_wdata"}, mem_wdata, 64'd0);
        check({name, "_out_data"}, out_data, 64'd0);
    endtask

    initial begin
        int g0;
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Basic transfer.
        launch(64'h1000);
        check("busy_after_start", 64'(busy), 64'd1);
        finish_xfer("basic", 1'b0);

        // Backpressure: credit limits grants to the FIFO depth.
        out_ready = 1'b0;
        g0 = grants;
        launch(64'h3000);
        repeat (20) tick();
        check("bp_grants", 64'(grants - g0), 64'd4);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_mem_req", 64'(mem_req), 64'd0);
        finish_xfer("bp", 1'b1);

        // Grant stall on word 2.
        stall_addr = 64'h1010;
        stall_left = 5;
        launch(64'h1000);
        finish_xfer("stall", 1'b0);
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Address wrap.
        launch(64'hFFFF_FFFF_FFFF_FFF8);
        finish_xfer("wrap", 1'b0);

        // Start while busy, then reset with late returns.
        lat = 6;
        launch(64'h1000);
        repeat (2) tick();
        start     = 1'b1;
        base_addr = 64'h5000;
        tick();
        start     = 1'b0;
        tick();
        d0 = done_cnt;
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("postrst_out_valid", 64'(out_valid), 64'd0);
            check("postrst_busy", 64'(busy), 64'd0);
        end
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("late_valid_seen", 64'(ignored_valids > 0), 64'd1);
        lat = 2;
        launch(64'h2000);
        finish_xfer("restart", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
